// File: rtl/abus_pkg.sv
// Shared abus slave definitions: FSM state encoding, master id width and
// the address-window decode used by every slave on the bus.
package abus_pkg;

  localparam int ABUS_MID_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } abus_slave_state_t;

  // True when addr falls inside [base, base+nb). Evaluated one bit wider
  // so a window ending at the top of the address space does not wrap.
  function automatic logic abus_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] nb);
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, nb};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/abus_reg.sv
// Single storage register with asynchronous reset value and write enable.
module abus_reg #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on write enable; return to the reset value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VALUE;
    else if (we) q <= d;
  end

endmodule

// File: rtl/abus_slave_regfile.sv
// abus slave holding NB_REGS registers in a contiguous address window.
// Four-phase req/ack handshake with an optional fixed number of wait states.
module abus_slave_regfile
  import abus_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0100,
  parameter int                    NB_REGS     = 8,
  parameter int                    REG_WIDTH   = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [REG_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                              abus_clk,
  input  logic                              abus_rst,
  input  logic                              abus_sreq,
  input  logic                              abus_swrite,
  input  logic                              abus_sread,
  input  logic                              abus_sabort,
  input  logic [ABUS_MID_WIDTH-1:0]         abus_smid,
  input  logic [ADDR_WIDTH-1:0]             abus_saddress,
  input  logic [DATA_WIDTH-1:0]             abus_swdata,
  output logic                              abus_sack,
  output logic [DATA_WIDTH-1:0]             abus_srdata,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   abus_sstrb,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   abus_skeep,
  output logic [NB_REGS*REG_WIDTH-1:0]      reg_q,
  output logic [NB_REGS-1:0]                reg_wstrb,
  output logic [ABUS_MID_WIDTH-1:0]         last_mid
);

  localparam int IDX_W  = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
  localparam int STRB_W = $clog2(DATA_WIDTH + 1);
  localparam logic [3:0]        WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [STRB_W-1:0] REG_CNT = STRB_W'(REG_WIDTH);

  abus_slave_state_t state, state_d;
  logic [3:0]                cnt, cnt_d;
  logic                      hit, accept, go_ack;
  logic [IDX_W-1:0]          idx_in, cap_idx, xfer_idx;
  logic [REG_WIDTH-1:0]      cap_wdata, xfer_wdata, rd_val;
  logic [ABUS_MID_WIDTH-1:0] cap_mid, xfer_mid;
  logic                      cap_wr, xfer_wr;
  logic [NB_REGS-1:0]        we;

  // Address decode and request qualification.
  always_comb begin
    hit    = abus_hit(32'(abus_saddress), 32'(BASE_ADDR), 32'(NB_REGS));
    idx_in = IDX_W'(abus_saddress - BASE_ADDR);
    accept = abus_sreq && hit && !abus_sabort && (abus_swrite ^ abus_sread);
  end

  // State and wait counter registers.
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; go_ack marks the edge on which the transfer commits.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    go_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ACK;
            go_ack  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (abus_sabort || !abus_sreq) begin
          state_d = IDLE;
        end else if (cnt == 4'd0) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!abus_sreq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; later changes on the bus inputs are ignored.
  always_ff @(posedge abus_clk) begin
    if (state == IDLE && accept) begin
      cap_idx   <= idx_in;
      cap_wdata <= abus_swdata[REG_WIDTH-1:0];
      cap_mid   <= abus_smid;
      cap_wr    <= abus_swrite;
    end
  end

  // With no wait states the commit happens on the capture edge itself,
  // so the transfer fields come straight from the bus while in IDLE.
  always_comb begin
    xfer_idx   = (state == IDLE) ? idx_in : cap_idx;
    xfer_wdata = (state == IDLE) ? abus_swdata[REG_WIDTH-1:0] : cap_wdata;
    xfer_mid   = (state == IDLE) ? abus_smid : cap_mid;
    xfer_wr    = (state == IDLE) ? abus_swrite : cap_wr;
    rd_val     = reg_q[xfer_idx*REG_WIDTH +: REG_WIDTH];
    we         = '0;
    if (go_ack && xfer_wr) we[xfer_idx] = 1'b1;
  end

  // Registered bus responses: set at commit, cleared once sreq drops.
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      abus_sack   <= 1'b0;
      abus_srdata <= '0;
      abus_sstrb  <= '0;
      abus_skeep  <= '0;
      reg_wstrb   <= '0;
      last_mid    <= '0;
    end else begin
      reg_wstrb <= we;
      if (go_ack) begin
        abus_sack   <= 1'b1;
        abus_srdata <= xfer_wr ? '0 : DATA_WIDTH'(rd_val);
        abus_sstrb  <= xfer_wr ? '0 : REG_CNT;
        abus_skeep  <= xfer_wr ? REG_CNT : '0;
        if (xfer_wr) last_mid <= xfer_mid;
      end else if (state == ACK && !abus_sreq) begin
        abus_sack   <= 1'b0;
        abus_srdata <= '0;
        abus_sstrb  <= '0;
        abus_skeep  <= '0;
      end
    end
  end

  // Register array.
  for (genvar i = 0; i < NB_REGS; i++) begin : g_reg
    abus_reg #(
      .WIDTH       (REG_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clk (abus_clk),
      .rst (abus_rst),
      .we  (we[i]),
      .d   (xfer_wdata),
      .q   (reg_q[i*REG_WIDTH +: REG_WIDTH])
    );
  end

endmodule
